// File: rtl/rand_synch_hold_checker_pkg.sv
// Shared types and helpers for the random hold-window checker.
package rand_synch_hold_checker_pkg;

  typedef enum logic {StFree, StHold} hold_state_e;

  localparam logic [31:0] LfsrTaps = 32'h8020_0003;

  // Increment that sticks at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] top;
    top = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (val >= top) ? val : val + 32'd1;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LfsrTaps) : (s >> 1);
  endfunction

endpackage

// File: rtl/rand_synch_hold_checker_timer.sv
// Window-length timer: reloads a pseudo-random count in [Min,Max] for the next window type
// and pulses expire_o on the last cycle of the current window.
module rand_synch_hold_checker_timer
  import rand_synch_hold_checker_pkg::*;
#(
  parameter int unsigned MinFreeCycles = 1,
  parameter int unsigned MaxFreeCycles = 4,
  parameter int unsigned MinHoldCycles = 2,
  parameter int unsigned MaxHoldCycles = 5,
  parameter int unsigned Seed          = 32'h0000_0001
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sel_hold_i,
  output logic expire_o
);

  localparam int unsigned FreeSpan = MaxFreeCycles - MinFreeCycles + 1;
  localparam int unsigned HoldSpan = MaxHoldCycles - MinHoldCycles + 1;
  // The first FREE window is drawn from the seed so it starts counting out of reset.
  localparam logic [31:0] FirstFree = 32'(MinFreeCycles + Seed % FreeSpan);

  logic [31:0] r_cnt, r_lfsr, w_draw;

  always_comb begin
    w_draw = sel_hold_i ? 32'(MinHoldCycles + r_lfsr % HoldSpan)
                        : 32'(MinFreeCycles + r_lfsr % FreeSpan);
  end

  assign expire_o = (r_cnt == 32'd1);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt  <= FirstFree;
      r_lfsr <= Seed;
    end else begin
      r_lfsr <= lfsr_next(r_lfsr);
      r_cnt  <= expire_o ? w_draw : r_cnt - 32'd1;
    end
  end

endmodule

// File: rtl/rand_synch_hold_checker.sv
// Drives hold_o in random FREE/HOLD windows and checks that data_i stays stable while held.
// Each posedge samples the data_i value of the cycle that just ended, tagged with that cycle's state.
module rand_synch_hold_checker
  import rand_synch_hold_checker_pkg::*;
#(
  parameter int unsigned MinFreeCycles = 1,
  parameter int unsigned MaxFreeCycles = 4,
  parameter int unsigned MinHoldCycles = 2,
  parameter int unsigned MaxHoldCycles = 5,
  parameter int unsigned CntWidth      = 16,
  parameter int unsigned Seed          = 32'h0000_0001
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                data_i,
  output logic                hold_o,
  output logic                err_o,
  output logic [CntWidth-1:0] win_cnt_o,
  output logic [CntWidth-1:0] chg_cnt_o,
  output logic [CntWidth-1:0] viol_cnt_o
);

  if (MinFreeCycles < 1 || MaxFreeCycles < MinFreeCycles || MinHoldCycles < 2 ||
      MaxHoldCycles < MinHoldCycles || CntWidth < 1 || CntWidth > 32) begin : g_param_check
    $fatal(1, "rand_synch_hold_checker: illegal parameter set");
  end

  hold_state_e         r_state, w_state_next;
  logic                w_expire, w_in_hold;
  logic [CntWidth-1:0] r_win_cnt, r_chg_cnt, r_viol_cnt;
  logic                r_err, r_prev, r_prev_vld, r_ref, r_ref_vld;

  function automatic logic [CntWidth-1:0] inc(input logic [CntWidth-1:0] v);
    return CntWidth'(sat_inc(32'(v), CntWidth));
  endfunction

  rand_synch_hold_checker_timer #(
    .MinFreeCycles(MinFreeCycles),
    .MaxFreeCycles(MaxFreeCycles),
    .MinHoldCycles(MinHoldCycles),
    .MaxHoldCycles(MaxHoldCycles),
    .Seed         (Seed)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .sel_hold_i(r_state == StFree),
    .expire_o  (w_expire)
  );

  assign w_in_hold = (r_state == StHold);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= StFree;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_expire) w_state_next = w_in_hold ? StFree : StHold;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_win_cnt  <= '0;
      r_chg_cnt  <= '0;
      r_viol_cnt <= '0;
      r_err      <= 1'b0;
      r_prev     <= 1'b0;
      r_prev_vld <= 1'b0;
      r_ref      <= 1'b0;
      r_ref_vld  <= 1'b0;
    end else begin
      if (r_prev_vld && (data_i != r_prev)) r_chg_cnt <= inc(r_chg_cnt);
      r_prev     <= data_i;
      r_prev_vld <= 1'b1;
      // First held sample may still carry the driver's last update, so it only sets the reference.
      if (w_in_hold) begin
        if (!r_ref_vld) begin
          r_ref     <= data_i;
          r_ref_vld <= 1'b1;
        end else if (data_i != r_ref) begin
          r_viol_cnt <= inc(r_viol_cnt);
          r_err      <= 1'b1;
        end
        if (w_expire) r_win_cnt <= inc(r_win_cnt);
      end else begin
        r_ref_vld <= 1'b0;
      end
    end
  end

  assign hold_o     = w_in_hold;
  assign err_o      = r_err;
  assign win_cnt_o  = r_win_cnt;
  assign chg_cnt_o  = r_chg_cnt;
  assign viol_cnt_o = r_viol_cnt;

endmodule

// File: tb/tb_rand_synch_hold_checker.sv
// Randomized bench: a random-window instance and a fixed 3/4-window narrow-counter instance,
// both compared every cycle against a behavioural model of the checking rules.
module tb_rand_synch_hold_checker;

  localparam int unsigned MinFreeA = 1, MaxFreeA = 4, MinHoldA = 2, MaxHoldA = 5;
  localparam int unsigned SatA = 65535, SatB = 15;

  logic        clk = 1'b0, rst = 1'b1;
  logic        data_a = 1'b0, data_b = 1'b0;
  logic        hold_a, err_a, hold_b, err_b;
  logic [15:0] win_a, chg_a, viol_a;
  logic [3:0]  win_b, chg_b, viol_b;

  always #5 clk = ~clk;

  rand_synch_hold_checker #(
    .MinFreeCycles(MinFreeA), .MaxFreeCycles(MaxFreeA),
    .MinHoldCycles(MinHoldA), .MaxHoldCycles(MaxHoldA),
    .CntWidth(16), .Seed(32'h1234_5679)
  ) u_dut_a (
    .clk_i(clk), .rst_i(rst), .data_i(data_a), .hold_o(hold_a), .err_o(err_a),
    .win_cnt_o(win_a), .chg_cnt_o(chg_a), .viol_cnt_o(viol_a)
  );

  rand_synch_hold_checker #(
    .MinFreeCycles(3), .MaxFreeCycles(3), .MinHoldCycles(4), .MaxHoldCycles(4),
    .CntWidth(4), .Seed(32'h0000_00a5)
  ) u_dut_b (
    .clk_i(clk), .rst_i(rst), .data_i(data_b), .hold_o(hold_b), .err_o(err_b),
    .win_cnt_o(win_b), .chg_cnt_o(chg_b), .viol_cnt_o(viol_b)
  );

  int unsigned n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model state, index 0 = random instance, 1 = fixed instance.
  int unsigned m_chg[2], m_viol[2], m_win[2], m_run;
  bit          m_prev[2], m_vld[2], m_ref[2], m_inwin[2], m_err[2], m_hlast[2];
  bit          d_cur[2];
  int unsigned k;

  function automatic int unsigned sat(input int unsigned v, input int unsigned mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_chg[i] = 0; m_viol[i] = 0; m_win[i] = 0;
      m_prev[i] = 0; m_vld[i] = 0; m_ref[i] = 0; m_inwin[i] = 0; m_err[i] = 0; m_hlast[i] = 0;
    end
    m_run = 0;
    k = 0;
  endtask

  // Modes: 0 holdable driver, 1 toggle, 2 constant 1, 3 random ignoring hold.
  task automatic step(input int mode_a, input int mode_b);
    bit hnow[2];
    bit hp;
    int mode;
    int unsigned mx;
    @(posedge clk);
    #1;
    k++;
    hnow[0] = hold_a;
    hnow[1] = hold_b;
    for (int i = 0; i < 2; i++) begin
      mx = (i == 0) ? SatA : SatB;
      hp = m_hlast[i];
      if (m_vld[i] && d_cur[i] != m_prev[i]) m_chg[i] = sat(m_chg[i], mx);
      m_prev[i] = d_cur[i];
      m_vld[i]  = 1;
      if (hp) begin
        if (!m_inwin[i]) begin
          m_ref[i]   = d_cur[i];
          m_inwin[i] = 1;
        end else if (d_cur[i] != m_ref[i]) begin
          m_viol[i] = sat(m_viol[i], mx);
          m_err[i]  = 1;
        end
      end else begin
        m_inwin[i] = 0;
      end
      if (hp && !hnow[i]) m_win[i] = sat(m_win[i], mx);
    end
    // Fixed instance: FREE 3 then HOLD 4, repeating from reset.
    check("hold_b_pattern", hold_b, ((k % 7) >= 3) ? 1 : 0);
    // Random instance: every window length must stay within its range.
    m_run++;
    if (hnow[0] != m_hlast[0]) begin
      check("hold_a_len_ok", (m_hlast[0] ? (m_run >= MinHoldA && m_run <= MaxHoldA)
                                         : (m_run >= MinFreeA && m_run <= MaxFreeA)), 1);
      m_run = 0;
    end else if (m_run == (m_hlast[0] ? MaxHoldA : MaxFreeA) + 1) begin
      check("hold_a_len_max", m_run, m_hlast[0] ? MaxHoldA : MaxFreeA);
    end
    check("win_a", win_a, m_win[0]);
    check("chg_a", chg_a, m_chg[0]);
    check("viol_a", viol_a, m_viol[0]);
    check("err_a", err_a, m_err[0]);
    check("win_b", win_b, m_win[1]);
    check("chg_b", chg_b, m_chg[1]);
    check("viol_b", viol_b, m_viol[1]);
    check("err_b", err_b, m_err[1]);
    // New data for the next cycle; a holdable driver only updates if hold was low last cycle.
    for (int i = 0; i < 2; i++) begin
      mode = (i == 0) ? mode_a : mode_b;
      case (mode)
        0:       if (!m_hlast[i]) d_cur[i] = 1'($urandom_range(0, 1));
        1:       d_cur[i] = ~d_cur[i];
        2:       d_cur[i] = 1'b1;
        default: d_cur[i] = 1'($urandom_range(0, 1));
      endcase
      m_hlast[i] = hnow[i];
    end
    data_a = d_cur[0];
    data_b = d_cur[1];
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    model_reset();
    data_a = d_cur[0];
    data_b = d_cur[1];
    rst = 1'b0;
    #1;
    check("rst_hold_a", hold_a, 0);
    check("rst_hold_b", hold_b, 0);
    check("rst_cnt_a", {win_a, chg_a, viol_a, 15'd0, err_a}, 0);
    check("rst_cnt_b", {win_b, chg_b, viol_b, 3'd0, err_b}, 0);
  endtask

  initial begin
    int guard;
    d_cur[0] = 1'b0;
    d_cur[1] = 1'b0;
    release_reset();

    // Holdable driver on A, toggling stub on B.
    for (int c = 0; c < 1000; c++) begin
      step(0, 1);
      if (k == 70) check("win_b_after_70", win_b, 10);
    end
    check("a_chg_nonzero", (chg_a != 0) ? 1 : 0, 1);
    check("a_err_clean", err_a, 0);
    check("b_chg_saturated", chg_b, SatB);
    check("b_err_sticky", err_b, 1);

    // Abort a HOLD window of A one cycle after it opens.
    guard = 0;
    while (!hold_a && guard < 20) begin
      step(0, 2);
      guard++;
    end
    check("a_hold_rose", hold_a, 1);
    step(0, 2);
    check("a_hold_pre_reset", hold_a, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_hold_a", hold_a, 0);
    check("async_cnt_a", {win_a, chg_a, viol_a, 15'd0, err_a}, 0);
    check("async_cnt_b", {win_b, chg_b, viol_b, 3'd0, err_b}, 0);
    d_cur[1] = 1'b1;
    release_reset();

    // Random data on A ignoring hold; constant 1 on B.
    for (int c = 0; c < 300; c++) step(3, 2);
    check("b_const_chg", chg_b, 0);
    check("b_const_viol", viol_b, 0);

    @(negedge clk);
    rst = 1'b1;
    d_cur[0] = 1'b1;
    release_reset();
    for (int c = 0; c < 200; c++) step(2, 1);
    check("a_const_chg", chg_a, 0);
    check("a_const_viol", viol_a, 0);
    check("b_resat", chg_b, SatB);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
